// File: rtl/sr_hr_writer.sv
// rtl/sr_hr_writer.sv - HR frame-buffer writer for 2x2 super-resolved quads
// Tracks LR pixel position and emits two 16-bit word writes (top/bottom HR rows) per quad.
module sr_hr_writer #(
  parameter int WIDTH  = 114,
  parameter int HEIGHT = 172,
  parameter int AW     = $clog2(2*WIDTH*HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [7:0]    in1,
  input  logic [7:0]    in2,
  input  logic [7:0]    in3,
  input  logic [7:0]    in4,
  output logic          wr_en,
  output logic [AW-1:0] wr_top_addr,
  output logic [15:0]   wr_top_data,
  output logic [AW-1:0] wr_bot_addr,
  output logic [15:0]   wr_bot_data,
  output logic          busy,
  output logic          frame_done,
  output logic          overflow
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [AW-1:0] ROW_W  = AW'(WIDTH);
  localparam logic [AW-1:0] ROW_2W = AW'(2*WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [XW-1:0] x, x_nx;
  logic [YW-1:0] y, y_nx;
  logic [AW-1:0] row_base, row_base_nx;
  logic          accept, last_px, overflow_nx;

  assign last_px = (x == XW'(WIDTH-1)) && (y == YW'(HEIGHT-1));

  always_comb begin
    state_nx    = state;
    x_nx        = x;
    y_nx        = y;
    row_base_nx = row_base;
    accept      = 1'b0;
    overflow_nx = overflow;
    if (clr) begin
      state_nx    = IDLE;
      x_nx        = '0;
      y_nx        = '0;
      row_base_nx = '0;
      overflow_nx = 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (in_valid) begin
            accept   = 1'b1;
            state_nx = last_px ? DONE : RUN;
            // row_base tracks 2y*WIDTH so no multiplier is needed for addresses
            if (x == XW'(WIDTH-1)) begin
              x_nx        = '0;
              y_nx        = y + YW'(1);
              row_base_nx = row_base + ROW_2W;
            end else begin
              x_nx = x + XW'(1);
            end
          end
        end
        DONE: begin
          if (in_valid) overflow_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
      wr_en       <= 1'b0;
      wr_top_addr <= '0;
      wr_top_data <= '0;
      wr_bot_addr <= '0;
      wr_bot_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state      <= state_nx;
      x          <= x_nx;
      y          <= y_nx;
      row_base   <= row_base_nx;
      wr_en      <= accept;
      busy       <= (state_nx == RUN);
      frame_done <= accept && last_px;
      overflow   <= overflow_nx;
      if (accept) begin
        wr_top_addr <= row_base + AW'(x);
        wr_bot_addr <= row_base + ROW_W + AW'(x);
        wr_top_data <= {in2, in1};
        wr_bot_data <= {in4, in3};
      end
    end
  end

endmodule
